// File: rtl/usb3_crc_engine.sv
// usb3_crc_engine
// Streaming CRC generator/checker for USB 3.0 framed data (CRC-32 for DPP
// payloads, CRC-16 for header packets, selected by parameters).
//
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   in_valid       beat present
//   in_first       first beat of a frame (qualified by in_valid)
//   in_last        last beat of a frame (qualified by in_valid)
//   in_data        beat; byte 0 = in_data[7:0] goes first, each byte LSB-first
//   in_be          byte enables; all ones except on the last beat
//   busy           a frame is being accumulated
//   crc_valid      one-cycle pulse, crc_out/crc_ok updated
//   crc_out        bit-reverse(LFSR) ^ XOR_OUT of the closed frame
//   crc_ok         crc_out matched RESIDUE (receive-side check)
//   frame_err      one-cycle pulse on a framing violation
//   dbg_state      current FSM state (0 = IDLE, 1 = ACCUM)
//
// Handshake: there is no backpressure. A beat is consumed on every rising
// clock edge where in_valid is high; in_first/in_last/in_data/in_be are only
// looked at in that cycle. Results appear as registered one-cycle pulses.
module usb3_crc_engine #(
  parameter int                CRC_W   = 32,
  parameter logic [31:0]       POLY    = 32'h04C11DB7,
  parameter logic [CRC_W-1:0]  INIT    = {CRC_W{1'b1}},
  parameter logic [CRC_W-1:0]  XOR_OUT = {CRC_W{1'b1}},
  parameter int                DATA_W  = 32,
  parameter logic [31:0]       RESIDUE = 32'h2144DF1C
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_first,
  input  logic                in_last,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_be,
  output logic                busy,
  output logic                crc_valid,
  output logic [CRC_W-1:0]    crc_out,
  output logic                crc_ok,
  output logic                frame_err,
  output logic                dbg_state
);

  localparam int               NB     = DATA_W / 8;
  localparam logic [CRC_W-1:0] POLY_W = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] RES_W  = RESIDUE[CRC_W-1:0];
  localparam logic [NB-1:0]    BE_ONE = NB'(1);

  typedef enum logic {S_IDLE = 1'b0, S_ACCUM = 1'b1} state_t;

  state_t           state, state_n;
  logic [CRC_W-1:0] lfsr, lfsr_n;
  logic [CRC_W-1:0] seed, upd, res_n;
  logic             done, err;
  logic             be_contig, be_bad;

  // Bit-serial MSB-first LFSR unrolled across all enabled bytes of a beat.
  function automatic logic [CRC_W-1:0] crc_update(input logic [CRC_W-1:0]  s,
                                                  input logic [DATA_W-1:0] d,
                                                  input logic [NB-1:0]     be);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = s;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) begin
        for (int i = 0; i < 8; i++) begin
          fb = c[CRC_W-1] ^ d[8*b+i];
          c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY_W : '0);
        end
      end
    end
    return c;
  endfunction

  function automatic logic [CRC_W-1:0] bit_rev(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) r[i] = v[CRC_W-1-i];
    return r;
  endfunction

  // A new frame (from IDLE, or a restart from ACCUM) always seeds from INIT.
  assign seed  = (state == S_IDLE || in_first) ? INIT : lfsr;
  assign upd   = crc_update(seed, in_data, in_be);
  assign res_n = bit_rev(upd) ^ XOR_OUT;

  // Contiguous-from-bit-0 masks (0,1,3,7,...) are exactly those where
  // adding one clears every set bit.
  assign be_contig = (((in_be + BE_ONE) & in_be) == '0);
  assign be_bad    = in_last ? (!be_contig || in_be == '0) : !(&in_be);

  always_comb begin
    state_n = state;
    lfsr_n  = lfsr;
    done    = 1'b0;
    err     = 1'b0;
    if (in_valid) begin
      if (state == S_IDLE && !in_first) begin
        // Stray beat with no open frame: dropped.
        err = 1'b1;
      end else begin
        // In ACCUM, in_first abandons the open frame without a result.
        err    = be_bad | (state == S_ACCUM && in_first);
        lfsr_n = upd;
        if (in_last) begin
          done    = 1'b1;
          state_n = S_IDLE;
        end else begin
          state_n = S_ACCUM;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      lfsr      <= INIT;
      crc_valid <= 1'b0;
      crc_out   <= '0;
      crc_ok    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      lfsr      <= lfsr_n;
      crc_valid <= done;
      frame_err <= err;
      if (done) begin
        crc_out <= res_n;
        crc_ok  <= (res_n == RES_W);
      end
    end
  end

  assign busy      = (state == S_ACCUM);
  assign dbg_state = state;

endmodule

// File: tb/tb_usb3_crc_engine.sv
// Bench for usb3_crc_engine at default parameters (CRC-32, 32-bit beats).
// The reference keeps the enabled bytes of the open frame in a queue and
// computes the standard reflected CRC-32 over them when the frame closes.
module tb_usb3_crc_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_be = '0;
  logic        busy, crc_valid, crc_ok, frame_err, dbg_state;
  logic [31:0] crc_out;

  usb3_crc_engine dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .in_data(in_data), .in_be(in_be), .busy(busy),
    .crc_valid(crc_valid), .crc_out(crc_out), .crc_ok(crc_ok),
    .frame_err(frame_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass = 0;
  logic        chk_en = 1'b0;
  logic [31:0] exp_q[$];
  logic [7:0]  frame_q[$];
  logic        in_frame = 1'b0;
  logic        exp_valid = 1'b0;
  logic        exp_ferr = 1'b0;
  logic        exp_busy = 1'b0;
  logic [31:0] hold_crc = '0;
  logic        hold_ok = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] ref_crc();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (frame_q[i]) begin
      c = c ^ {24'h0, frame_q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Framing rules applied to one driven cycle; sets what the outputs must
  // show after the next rising edge.
  task automatic model_beat(input logic v, input logic f, input logic l,
                            input logic [31:0] d, input logic [3:0] be);
    logic be_err;
    int   cnt;
    exp_valid = 1'b0;
    exp_ferr  = 1'b0;
    if (v) begin
      cnt = $countones(be);
      if (l) be_err = (cnt == 0) || (int'(be) != (1 << cnt) - 1);
      else   be_err = (be != 4'hF);
      if (!in_frame && !f) begin
        exp_ferr = 1'b1;
      end else begin
        if (in_frame && f) exp_ferr = 1'b1;
        if (be_err) exp_ferr = 1'b1;
        if (f) frame_q.delete();
        for (int b = 0; b < 4; b++) if (be[b]) frame_q.push_back(d[8*b +: 8]);
        if (l) begin
          exp_valid = 1'b1;
          exp_q.push_back(ref_crc());
          in_frame = 1'b0;
        end else begin
          in_frame = 1'b1;
        end
      end
    end
    exp_busy = in_frame;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic f, input logic l,
                      input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    in_valid = v;
    in_first = f;
    in_last  = l;
    in_data  = d;
    in_be    = be;
    model_beat(v, f, l, d, be);
  endtask

  task automatic idle();
    step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
  endtask

  task automatic send_123456789();
    step(1'b1, 1'b1, 1'b0, 32'h34333231, 4'hF);
    step(1'b1, 1'b0, 1'b0, 32'h38373635, 4'hF);
    step(1'b1, 1'b0, 1'b1, 32'h00000039, 4'b0001);
  endtask

  // Checks the result registered by the edge that just follows the last beat.
  task automatic after_edge_expect(input string name, input logic [31:0] c, input logic ok);
    @(posedge clk);
    #3;
    check({name, "_valid"}, {31'h0, crc_valid}, 32'h1);
    check({name, "_crc"}, crc_out, c);
    check({name, "_ok"}, {31'h0, crc_ok}, {31'h0, ok});
  endtask

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    #2;
    if (chk_en && !rst) begin
      if (exp_valid) begin
        if (exp_q.size() == 0) begin
          $display("FAIL exp_q_empty: got 0 entries expected 1");
          n_checks++;
        end else begin
          hold_crc = exp_q.pop_front();
          hold_ok  = (hold_crc == 32'h2144DF1C);
        end
      end
      check("busy", {31'h0, busy}, {31'h0, exp_busy});
      check("dbg_state", {31'h0, dbg_state}, {31'h0, exp_busy});
      check("crc_valid", {31'h0, crc_valid}, {31'h0, exp_valid});
      check("frame_err", {31'h0, frame_err}, {31'h0, exp_ferr});
      check("crc_out", crc_out, hold_crc);
      check("crc_ok", {31'h0, crc_ok}, {31'h0, hold_ok});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] be;
    logic       f;
    int         kind, nb;

    // Model self-check on the well-known CRC-32 check string.
    frame_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("model_check_string", ref_crc(), 32'hCBF43926);
    frame_q.delete();

    #12;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_crc_valid", {31'h0, crc_valid}, 32'h0);
    check("rst_crc_out", crc_out, 32'h0);
    check("rst_crc_ok", {31'h0, crc_ok}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // Check string.
    send_123456789();
    after_edge_expect("check_str", 32'hCBF43926, 1'b0);

    // Data plus its own CRC, little-endian: residue.
    step(1'b1, 1'b1, 1'b0, 32'h34333231, 4'hF);
    step(1'b1, 1'b0, 1'b0, 32'h38373635, 4'hF);
    step(1'b1, 1'b0, 1'b0, 32'hF4392639, 4'hF);
    step(1'b1, 1'b0, 1'b1, 32'h000000CB, 4'b0001);
    after_edge_expect("residue", 32'h2144DF1C, 1'b1);

    // Same with one data bit flipped: bad verdict.
    step(1'b1, 1'b1, 1'b0, 32'h34333231, 4'hF);
    step(1'b1, 1'b0, 1'b0, 32'h38373625, 4'hF);
    step(1'b1, 1'b0, 1'b0, 32'hF4392639, 4'hF);
    step(1'b1, 1'b0, 1'b1, 32'h000000CB, 4'b0001);
    @(posedge clk);
    #3;
    check("flipped_ok", {31'h0, crc_ok}, 32'h0);

    // Empty single-beat frame.
    step(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 4'b0000);
    @(posedge clk);
    #3;
    check("empty_ferr", {31'h0, frame_err}, 32'h1);
    check("empty_crc", crc_out, 32'h00000000);

    // Mid-frame restart, then a good frame.
    step(1'b1, 1'b1, 1'b0, 32'h11223344, 4'hF);
    step(1'b1, 1'b0, 1'b0, 32'h55667788, 4'hF);
    send_123456789();
    after_edge_expect("restart", 32'hCBF43926, 1'b0);

    // Stray beat while idle.
    idle();
    step(1'b1, 1'b0, 1'b1, 32'hA5A5A5A5, 4'hF);
    @(posedge clk);
    #3;
    check("stray_ferr", {31'h0, frame_err}, 32'h1);
    check("stray_busy", {31'h0, busy}, 32'h0);
    send_123456789();
    after_edge_expect("after_stray", 32'hCBF43926, 1'b0);

    // Asynchronous reset mid-frame.
    step(1'b1, 1'b1, 1'b0, 32'h34333231, 4'hF);
    step(1'b1, 1'b0, 1'b0, 32'h00000000, 4'b0011);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy", {31'h0, busy}, 32'h0);
    check("arst_crc_valid", {31'h0, crc_valid}, 32'h0);
    check("arst_frame_err", {31'h0, frame_err}, 32'h0);
    check("arst_crc_out", crc_out, 32'h0);
    in_valid = 1'b0;
    in_frame = 1'b0;
    frame_q.delete();
    exp_q.delete();
    exp_valid = 1'b0;
    exp_ferr = 1'b0;
    exp_busy = 1'b0;
    hold_crc = '0;
    hold_ok = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, 32'h38373635, 4'hF);
    send_123456789();
    after_edge_expect("after_arst", 32'hCBF43926, 1'b0);

    // Randomized frames with occasional framing faults and idle gaps.
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      nb = $urandom_range(1, 5);
      if (kind == 0) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom, 4'hF);
      for (int k = 0; k < nb; k++) begin
        f  = (k == 0) || (kind == 3 && k == 1);
        be = (k == nb - 1) ? 4'((1 << $urandom_range(1, 4)) - 1) : 4'hF;
        if (kind == 1 && k == nb - 1) be = 4'($urandom_range(0, 15));
        if (kind == 2 && k != nb - 1) be = 4'($urandom_range(0, 15));
        step(1'b1, f, (k == nb - 1), $urandom, be);
        if ($urandom_range(0, 3) == 0) idle();
      end
    end
    repeat (3) idle();
    @(posedge clk);
    #3;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
